serial_receiver: RTL and testbench
==================================

Name: serial_receiver

Overview:
- UART-style 8N1 receiver; companion to the serial_transmitter.
- Oversamples the asynchronous serial_rx pin in the system clock domain and samples each bit at mid-bit.
- Presents each received byte with a one-cycle valid strobe.
- Sits between the board RX pin and consumer logic (command parser / loopback).

Parameters:
CLOCKS_PER_BIT, 5000, system clocks per serial bit (e.g. 48 MHz / 9600 baud); must be >= 4
SYNC_STAGES, 2, flip-flops in the input synchronizer; must be >= 2

Ports:
clock  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-high reset
serial_rx  input  1  raw serial line, idle high, asynchronous to clock
rx_data  output  8  last received byte, LSB first on the wire; held until the next byte completes
rx_data_valid  output  1  one-cycle pulse when rx_data is updated
rx_busy  output  1  high while a frame is in progress (any state other than IDLE)
framing_error  output  1  present only with SERIAL_RECEIVER_FRAMING_CHECK_EN; one-cycle pulse on a bad stop bit

Behaviour:
- Reset: one clock; reset is asynchronous and active-high.
  - Synchronizer flops reset to 1.
  - FSM resets to IDLE, bit counter and clock counter to 0.
  - Outputs reset to rx_data=8'h00, rx_data_valid=0, rx_busy=0, framing_error=0.
- Synchronizer:
  - SYNC_STAGES flops; rx_s is the last stage.
  - Pin-to-rx_s latency is SYNC_STAGES cycles.
  - All FSM decisions use rx_s only.
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
- IDLE:
  - On rx_s==0 go to START and clear the clock counter; this cycle is t0.
- START:
  - At t0+CLOCKS_PER_BIT/2 (integer divide), sample rx_s.
  - 1 -> false start (glitch), return to IDLE, no output.
  - 0 -> go to DATA, clear the clock counter and bit index.
- DATA:
  - Every CLOCKS_PER_BIT cycles, sample rx_s into shift register bit[index], LSB first.
  - Samples fall at t0+CLOCKS_PER_BIT/2+k*CLOCKS_PER_BIT, k=1..8.
  - After the 8th sample go to STOP.
- STOP:
  - Sample at k=9.
  - rx_s==1 -> load rx_data, assert rx_data_valid in the following cycle for exactly one cycle, go to IDLE.
  - rx_s==0 -> framing error: rx_data is not updated, no valid pulse, framing_error pulses (if enabled), go to WAIT_HIGH.
- WAIT_HIGH:
  - Stay until rx_s==1, then go to IDLE.
  - Prevents a stuck-low line or break from being decoded as 8'h00 frames.
- Back-to-back frames:
  - Returning to IDLE at mid-stop-bit allows a start edge immediately after the stop bit with zero idle gap.
- No backpressure: the consumer must accept the byte on the valid pulse.
  - A new byte overwrites rx_data.
- Counter width: $clog2(CLOCKS_PER_BIT); the counter never exceeds CLOCKS_PER_BIT-1.
- rx_busy is combinational from state (state != IDLE).
- Reset asserted mid-frame aborts the frame with no partial output.
  - After release, the receiver waits in IDLE; a line already low is treated as a new start.

Optional Feature:
SERIAL_RECEIVER_FRAMING_CHECK_EN
- Defined:
  - framing_error port exists and pulses one cycle (same cycle a valid pulse would have occurred) on a low stop bit.
  - The bad frame is discarded and the FSM enters WAIT_HIGH.
- Undefined:
  - No framing_error port.
  - The stop-bit value is ignored: every frame reaching STOP loads rx_data and pulses rx_data_valid.
  - WAIT_HIGH is still entered if the stop sample is 0, after the valid pulse.

Decomposition:
- Package serial_pkg:
  - rx_state_t enum (IDLE, START, DATA, STOP, WAIT_HIGH).
  - DATA_BITS=8.
  - DEFAULT_CLOCKS_PER_BIT=5000, shared with the transmitter.
- Sub-module serial_synchronizer (parameter SYNC_STAGES, reset value 1).
  - Reusable for other asynchronous pins.

Test Plan:
- Drive 8'hAB at 5000 clocks/bit, 8N1, after 5000 idle cycles -> single rx_data_valid pulse with rx_data=8'hAB; rx_busy high throughout the frame; valid at t0+2500+9*5000+1.
- Drive 8'h00 immediately after an 8'h55 stop bit, zero gap -> two valid pulses, 8'h55 then 8'h00, separated by 10*5000 cycles.
- Pulse serial_rx low for 100 cycles, then high -> no valid pulse, no framing_error; rx_busy returns low 2500 cycles after t0.
- Frame 8'hC3 with stop bit driven low, line held low 20000 more cycles -> with the macro: framing_error pulse, no valid, rx_data unchanged, no further frames until the line returns high. Without the macro: one valid pulse with 8'hC3, then no frames while the line is low.
- Assert reset for one cycle during data bit 4 of 8'hAB, then send 8'h3C -> no output for the aborted frame; rx_data=8'h3C delivered correctly.
- Loopback: connect serial_transmitter serial_tx to serial_rx and send 8'hAB, 8'h00, 8'hFF -> identical bytes received in order.

Source files
------------

// File: rtl/serial_pkg.sv
// rtl/serial_pkg.sv - shared types and constants for the serial receiver/transmitter pair
//
// Contents:
//   rx_state_t             receiver FSM states
//   DATA_BITS              payload bits per frame (8N1)
//   DEFAULT_CLOCKS_PER_BIT default bit period in system clocks, shared with the transmitter
package serial_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } rx_state_t;

    localparam int DATA_BITS              = 8;
    localparam int DEFAULT_CLOCKS_PER_BIT = 5000;

endpackage

// File: rtl/serial_synchronizer.sv
// rtl/serial_synchronizer.sv - multi-flop synchronizer for an asynchronous single-bit input
//
// Parameters:
//   SYNC_STAGES  number of flops in the chain (>= 2)
//   RESET_VALUE  value every flop takes in reset (1 suits idle-high serial lines)
// Ports:
//   i_clock  system clock
//   i_reset  asynchronous active-high reset
//   i_async  raw asynchronous input
//   o_sync   synchronized output, SYNC_STAGES cycles behind i_async
module serial_synchronizer #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VALUE = 1'b1
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_async,
    output logic o_sync
);

    logic [SYNC_STAGES-1:0] r_sync;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_sync <= {SYNC_STAGES{RESET_VALUE}};
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
        end
    end

    assign o_sync = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/serial_receiver.sv
// rtl/serial_receiver.sv - UART-style 8N1 receiver with mid-bit sampling
//
// Optional feature macro: SERIAL_RECEIVER_FRAMING_CHECK_EN
//   defined   : o_framing_error exists; a low stop bit discards the frame
//   undefined : stop-bit value ignored for delivery; every frame reaching STOP is delivered
//
// Parameters:
//   CLOCKS_PER_BIT  system clocks per serial bit (>= 4)
//   SYNC_STAGES     flops in the input synchronizer (>= 2)
// Ports:
//   i_clock          system clock, rising edge
//   i_reset          asynchronous active-high reset
//   i_serial_rx      raw serial line, idle high
//   o_rx_data        last received byte, held until the next byte completes
//   o_rx_data_valid  one-cycle pulse when o_rx_data is updated
//   o_rx_busy        high while a frame is in progress (state != IDLE)
//   o_framing_error  one-cycle pulse on a bad stop bit (feature macro only)
module serial_receiver
    import serial_pkg::*;
#(
    parameter int CLOCKS_PER_BIT = DEFAULT_CLOCKS_PER_BIT,
    parameter int SYNC_STAGES    = 2
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_serial_rx,
    output logic [DATA_BITS-1:0] o_rx_data,
    output logic                 o_rx_data_valid,
`ifdef SERIAL_RECEIVER_FRAMING_CHECK_EN
    output logic                 o_framing_error,
`endif
    output logic                 o_rx_busy
);

    localparam int CW = $clog2(CLOCKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS);

    // START samples in the cycle that is CLOCKS_PER_BIT/2 after t0; the counter
    // reads 0 in the cycle after t0, hence the -1.
    localparam logic [CW-1:0] CNT_HALF = CW'(CLOCKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLOCKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

    logic w_rx_s;

    rx_state_t            r_state;
    logic [CW-1:0]        r_clk_cnt;
    logic [IW-1:0]        r_bit_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] r_rx_data;
    logic                 r_rx_data_valid;

    rx_state_t            w_state_next;
    logic [CW-1:0]        w_clk_cnt_next;
    logic [IW-1:0]        w_bit_idx_next;
    logic [DATA_BITS-1:0] w_shift_next;
    logic                 w_load;

`ifdef SERIAL_RECEIVER_FRAMING_CHECK_EN
    logic r_framing_error;
    logic w_framing_error;
`endif

    serial_synchronizer #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VALUE (1'b1)
    ) u_rx_sync (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_async (i_serial_rx),
        .o_sync  (w_rx_s)
    );

    always_comb begin
        w_state_next   = r_state;
        w_clk_cnt_next = r_clk_cnt + CW'(1);
        w_bit_idx_next = r_bit_idx;
        w_shift_next   = r_shift;
        w_load         = 1'b0;
`ifdef SERIAL_RECEIVER_FRAMING_CHECK_EN
        w_framing_error = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                w_clk_cnt_next = '0;
                if (!w_rx_s) begin
                    w_state_next = START;
                end
            end
            START: begin
                if (r_clk_cnt == CNT_HALF) begin
                    w_clk_cnt_next = '0;
                    w_bit_idx_next = '0;
                    // A start bit that is already high again at mid-bit was a glitch.
                    w_state_next   = w_rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (r_clk_cnt == CNT_LAST) begin
                    w_clk_cnt_next          = '0;
                    w_shift_next[r_bit_idx] = w_rx_s;
                    if (r_bit_idx == IDX_LAST) begin
                        w_state_next = STOP;
                    end else begin
                        w_bit_idx_next = r_bit_idx + IW'(1);
                    end
                end
            end
            STOP: begin
                if (r_clk_cnt == CNT_LAST) begin
                    w_clk_cnt_next = '0;
                    // Leaving at mid-stop-bit lets a start edge follow with zero gap.
`ifdef SERIAL_RECEIVER_FRAMING_CHECK_EN
                    if (w_rx_s) begin
                        w_load       = 1'b1;
                        w_state_next = IDLE;
                    end else begin
                        w_framing_error = 1'b1;
                        w_state_next    = WAIT_HIGH;
                    end
`else
                    w_load       = 1'b1;
                    w_state_next = w_rx_s ? IDLE : WAIT_HIGH;
`endif
                end
            end
            WAIT_HIGH: begin
                // A line held low (break) must not be decoded as a stream of 8'h00.
                w_clk_cnt_next = '0;
                if (w_rx_s) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_clk_cnt_next = '0;
                w_state_next   = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state         <= IDLE;
            r_clk_cnt       <= '0;
            r_bit_idx       <= '0;
            r_shift         <= '0;
            r_rx_data       <= '0;
            r_rx_data_valid <= 1'b0;
        end else begin
            r_state         <= w_state_next;
            r_clk_cnt       <= w_clk_cnt_next;
            r_bit_idx       <= w_bit_idx_next;
            r_shift         <= w_shift_next;
            r_rx_data_valid <= w_load;
            if (w_load) begin
                r_rx_data <= r_shift;
            end
        end
    end

`ifdef SERIAL_RECEIVER_FRAMING_CHECK_EN
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_framing_error <= 1'b0;
        end else begin
            r_framing_error <= w_framing_error;
        end
    end

    assign o_framing_error = r_framing_error;
`endif

    assign o_rx_data       = r_rx_data;
    assign o_rx_data_valid = r_rx_data_valid;
    assign o_rx_busy       = (r_state != IDLE);

endmodule

// File: tb/tb_serial_receiver.sv
// tb/tb_serial_receiver.sv - self-checking bench for serial_receiver
module tb_serial_receiver;

    localparam int CPB  = 16;
    localparam int SYNC = 2;
    localparam int HALF = CPB / 2;
    // Cycle (relative to driving the start bit) in which rx_data_valid is seen.
    localparam int LAT  = SYNC + HALF + 9 * CPB + 1;

    typedef struct {
        logic [7:0] data;
        int         cyc;
    } exp_t;

    logic       clock;
    logic       reset;
    logic       serial_rx;
    logic [7:0] o_rx_data;
    logic       o_rx_data_valid;
    logic       o_rx_busy;
`ifdef SERIAL_RECEIVER_FRAMING_CHECK_EN
    logic       o_framing_error;
    int         ferr_q[$];
`endif

    int   cyc;
    int   n_cmp;
    int   n_fail;
    exp_t exp_q[$];

    serial_receiver #(
        .CLOCKS_PER_BIT (CPB),
        .SYNC_STAGES    (SYNC)
    ) dut (
        .i_clock         (clock),
        .i_reset         (reset),
        .i_serial_rx     (serial_rx),
        .o_rx_data       (o_rx_data),
        .o_rx_data_valid (o_rx_data_valid),
`ifdef SERIAL_RECEIVER_FRAMING_CHECK_EN
        .o_framing_error (o_framing_error),
`endif
        .o_rx_busy       (o_rx_busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Output monitor: every valid/framing pulse is matched against the scoreboard.
    always @(negedge clock) begin
        exp_t e;
        if (o_rx_data_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_valid", 32'(o_rx_data_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("rx_data", 32'(o_rx_data), 32'(e.data));
                check("valid_cycle", cyc, e.cyc);
            end
        end
`ifdef SERIAL_RECEIVER_FRAMING_CHECK_EN
        if (o_framing_error) begin
            if (ferr_q.size() == 0) begin
                check("unexpected_ferr", 32'(o_framing_error), 32'd0);
            end else begin
                check("ferr_cycle", cyc, ferr_q.pop_front());
            end
        end
`endif
    end

    // Drives one 8N1 frame starting now; abort_at>=0 pulses reset mid-way through that frame bit.
    task automatic send_byte(input logic [7:0] b, input logic stop_bit, input int abort_at,
                             input logic exp_valid, input logic chk_busy);
        logic [9:0] fr;
        exp_t       e;
        fr = {stop_bit, b, 1'b0};
        if (exp_valid) begin
            e.data = b;
            e.cyc  = cyc + LAT;
            exp_q.push_back(e);
        end
        for (int i = 0; i < 10; i++) begin
            serial_rx = fr[i];
            for (int j = 0; j < CPB; j++) begin
                if (j == HALF) begin
                    if (chk_busy) check("busy_in_frame", 32'(o_rx_busy), 32'd1);
                    if (i == abort_at) begin
                        reset = 1'b1;
                        #1;
                        check("abort_rx_data", 32'(o_rx_data), 32'h00);
                        check("abort_busy", 32'(o_rx_busy), 32'd0);
                        @(posedge clock);
                        #1;
                        reset     = 1'b0;
                        serial_rx = 1'b1;
                        return;
                    end
                end
                @(posedge clock);
                #1;
            end
        end
    endtask

    initial begin
        int c;
        n_cmp     = 0;
        n_fail    = 0;
        reset     = 1'b1;
        serial_rx = 1'b1;
        step(3);
        check("reset_rx_data", 32'(o_rx_data), 32'h00);
        check("reset_valid", 32'(o_rx_data_valid), 32'd0);
        check("reset_busy", 32'(o_rx_busy), 32'd0);
`ifdef SERIAL_RECEIVER_FRAMING_CHECK_EN
        check("reset_ferr", 32'(o_framing_error), 32'd0);
`endif
        reset = 1'b0;
        step(50);

        // Single frame, busy checked at every bit centre.
        send_byte(8'hAB, 1'b1, -1, 1'b1, 1'b1);
        step(4);
        check("busy_after_ab", 32'(o_rx_busy), 32'd0);
        check("held_ab", 32'(o_rx_data), 32'hAB);

        // Back-to-back frames with zero idle gap.
        send_byte(8'h55, 1'b1, -1, 1'b1, 1'b0);
        send_byte(8'h00, 1'b1, -1, 1'b1, 1'b0);
        step(20);
        check("held_00", 32'(o_rx_data), 32'h00);

        // Glitch shorter than half a bit: rejected at the START sample.
        c = cyc;
        serial_rx = 1'b0;
        step(4);
        serial_rx = 1'b1;
        step(c + SYNC + HALF - cyc);
        check("glitch_busy_hi", 32'(o_rx_busy), 32'd1);
        step(1);
        check("glitch_busy_lo", 32'(o_rx_busy), 32'd0);
        step(30);
        check("glitch_rx_data", 32'(o_rx_data), 32'h00);

        // Low stop bit followed by a long break.
`ifdef SERIAL_RECEIVER_FRAMING_CHECK_EN
        ferr_q.push_back(cyc + LAT);
        send_byte(8'hC3, 1'b0, -1, 1'b0, 1'b0);
`else
        send_byte(8'hC3, 1'b0, -1, 1'b1, 1'b0);
`endif
        step(4 * CPB);
        check("break_busy", 32'(o_rx_busy), 32'd1);
`ifdef SERIAL_RECEIVER_FRAMING_CHECK_EN
        check("break_rx_data", 32'(o_rx_data), 32'h00);
`else
        check("break_rx_data", 32'(o_rx_data), 32'hC3);
`endif
        serial_rx = 1'b1;
        step(SYNC + 3);
        check("break_release_busy", 32'(o_rx_busy), 32'd0);
        step(20);

        // Reset in the middle of data bit 4, then a clean frame.
        send_byte(8'hAB, 1'b1, 5, 1'b0, 1'b0);
        check("post_reset_valid", 32'(o_rx_data_valid), 32'd0);
        step(3 * CPB);
        check("post_reset_busy", 32'(o_rx_busy), 32'd0);
        send_byte(8'h3C, 1'b1, -1, 1'b1, 1'b0);
        step(4);
        check("held_3c", 32'(o_rx_data), 32'h3C);

        // Continuous byte stream, as a transmitter in loopback would produce.
        send_byte(8'hAB, 1'b1, -1, 1'b1, 1'b0);
        send_byte(8'h00, 1'b1, -1, 1'b1, 1'b0);
        send_byte(8'hFF, 1'b1, -1, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) begin
            send_byte(8'($urandom_range(0, 255)), 1'b1, -1, 1'b1, 1'b0);
        end
        step(3 * CPB);

        check("pending_expected", exp_q.size(), 32'd0);
`ifdef SERIAL_RECEIVER_FRAMING_CHECK_EN
        check("pending_ferr", ferr_q.size(), 32'd0);
`endif
        check("final_busy", 32'(o_rx_busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
